time_syn_tx: RTL and testbench

- Transmit-side framer for the time-synchronisation control channel.
- Turns three request types into fixed 8-beat AXI4-Stream control frames: timestamp (marker 0x66), standard time (marker 0x88) and return timestamp (marker 0x55).
- Output feeds the control TX port; the far-end time_syn_rx decodes the frames.
- Frame layout: beat0 = 64-bit marker, beat1 = 64-bit payload, beats2..7 = zero padding, tlast on beat7.

---
 rtl/time_syn_tx.sv | 157 +++++++++++++++
 tb/tb_time_syn_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_syn_tx.sv
// Transmit framer for the time-sync control channel: turns timestamp, standard-time and
// return requests into fixed-length AXI4-Stream frames (marker, payload, zero padding).
module time_syn_tx #(
  parameter int unsigned P_FRAME_LEN = 8,
  parameter logic [63:0] P_TS_COMP   = 64'd0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_local_time,
  input  logic        i_send_ts,
  input  logic        i_send_std,
  input  logic [63:0] i_std_time,
  input  logic        i_send_return,
  input  logic [63:0] i_return_ts,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        m_ctrl_tx_axis_tvalid,
  output logic [63:0] m_ctrl_tx_axis_tdata,
  output logic        m_ctrl_tx_axis_tlast,
  output logic [7:0]  m_ctrl_tx_axis_tkeep,
  output logic        m_ctrl_tx_axis_tuser,
  input  logic        m_ctrl_tx_axis_tready
);

  localparam int unsigned     CntW     = $clog2(P_FRAME_LEN);
  localparam logic [CntW-1:0] LastBeat = CntW'(P_FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StMark, StPay, StPad} state_e;
  typedef enum logic [1:0] {TyTs, TyStd, TyRet} type_e;

  state_e          state_q, state_d;
  type_e           sel_q, sel_d, arb;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pend_ts_q, pend_std_q, pend_ret_q;
  logic [63:0]     std_pay_q, ret_pay_q, frm_pay_q, frm_pay_d;
  logic            done_q;
  logic            want_ts, want_std, want_ret, any_want;
  logic            hs, beat0_hs, last_beat;

  // Incoming pulses count as pending so a request can reach the wire on the next cycle.
  assign want_ts   = pend_ts_q  | i_send_ts;
  assign want_std  = pend_std_q | i_send_std;
  assign want_ret  = pend_ret_q | i_send_return;
  assign any_want  = want_ts | want_std | want_ret;
  assign arb       = want_ret ? TyRet : (want_std ? TyStd : TyTs);
  assign hs        = m_ctrl_tx_axis_tvalid & m_ctrl_tx_axis_tready;
  assign beat0_hs  = (state_q == StMark) & hs;
  assign last_beat = (state_q == StPad) & (cnt_q == LastBeat);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_want) begin
          state_d = StMark;
          sel_d   = arb;
        end
      end
      StMark: begin
        if (hs) begin
          state_d = StPay;
          cnt_d   = CntW'(1);
        end
      end
      StPay: begin
        if (hs) begin
          state_d = StPad;
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      StPad: begin
        if (hs) begin
          if (last_beat) begin
            cnt_d = '0;
            if (any_want) begin
              state_d = StMark;
              sel_d   = arb;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    frm_pay_d = frm_pay_q;
    if (beat0_hs) begin
      case (sel_q)
        TyStd:   frm_pay_d = std_pay_q;
        TyRet:   frm_pay_d = ret_pay_q;
        default: frm_pay_d = i_local_time + P_TS_COMP;
      endcase
    end
  end

  // A same-type request on the beat0 handshake cycle keeps the flag set.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sel_q      <= TyTs;
      cnt_q      <= '0;
      pend_ts_q  <= 1'b0;
      pend_std_q <= 1'b0;
      pend_ret_q <= 1'b0;
      std_pay_q  <= '0;
      ret_pay_q  <= '0;
      frm_pay_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      pend_ts_q  <= i_send_ts     | (pend_ts_q  & ~(beat0_hs & (sel_q == TyTs)));
      pend_std_q <= i_send_std    | (pend_std_q & ~(beat0_hs & (sel_q == TyStd)));
      pend_ret_q <= i_send_return | (pend_ret_q & ~(beat0_hs & (sel_q == TyRet)));
      if (i_send_std)    std_pay_q <= i_std_time;
      if (i_send_return) ret_pay_q <= i_return_ts;
      frm_pay_q  <= frm_pay_d;
      done_q     <= last_beat & hs;
    end
  end

  always_comb begin
    m_ctrl_tx_axis_tvalid = (state_q != StIdle);
    m_ctrl_tx_axis_tdata  = '0;
    m_ctrl_tx_axis_tlast  = last_beat;
    m_ctrl_tx_axis_tkeep  = {8{m_ctrl_tx_axis_tvalid}};
    m_ctrl_tx_axis_tuser  = 1'b0;
    o_frame_done          = done_q;
    o_busy                = m_ctrl_tx_axis_tvalid | done_q;
    unique case (state_q)
      StMark: begin
        case (sel_q)
          TyStd:   m_ctrl_tx_axis_tdata = 64'h88;
          TyRet:   m_ctrl_tx_axis_tdata = 64'h55;
          default: m_ctrl_tx_axis_tdata = 64'h66;
        endcase
      end
      StPay:   m_ctrl_tx_axis_tdata = frm_pay_q;
      default: m_ctrl_tx_axis_tdata = '0;
    endcase
  end

endmodule

// File: tb/tb_time_syn_tx.sv
// Directed bench for time_syn_tx: single, priority, backpressure, overwrite, collision and
// mid-frame reset scenarios with hand-computed expected beats.
module tb_time_syn_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] local_time;
  logic        send_ts, send_std, send_ret;
  logic [63:0] std_time, ret_ts;
  logic        busy, frame_done;
  logic        tvalid, tlast, tuser, tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  time_syn_tx #(
    .P_FRAME_LEN(8),
    .P_TS_COMP  (64'd5)
  ) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_local_time          (local_time),
    .i_send_ts             (send_ts),
    .i_send_std            (send_std),
    .i_std_time            (std_time),
    .i_send_return         (send_ret),
    .i_return_ts           (ret_ts),
    .o_busy                (busy),
    .o_frame_done          (frame_done),
    .m_ctrl_tx_axis_tvalid (tvalid),
    .m_ctrl_tx_axis_tdata  (tdata),
    .m_ctrl_tx_axis_tlast  (tlast),
    .m_ctrl_tx_axis_tkeep  (tkeep),
    .m_ctrl_tx_axis_tuser  (tuser),
    .m_ctrl_tx_axis_tready (tready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    send_ts  = 1'b0;
    send_std = 1'b0;
    send_ret = 1'b0;
  endtask

  // Request inputs already driven; check the request cycle itself is still idle.
  task automatic req_cycle(input string tag);
    @(negedge clk);
    chk({tag, "_idle"}, {63'd0, tvalid}, 64'd0);
    next_cyc();
    clear_reqs();
  endtask

  // Checks beats 0..n-1 of a frame with tready high; requests drop after beat0.
  task automatic check_beats(input string tag, input logic [63:0] mark,
                             input logic [63:0] pay, input int n);
    logic [63:0] exp;
    for (int i = 0; i < n; i++) begin
      exp = (i == 0) ? mark : ((i == 1) ? pay : 64'd0);
      @(negedge clk);
      chk($sformatf("%s_valid%0d", tag, i), {63'd0, tvalid}, 64'd1);
      chk($sformatf("%s_data%0d", tag, i), tdata, exp);
      chk($sformatf("%s_last%0d", tag, i), {63'd0, tlast}, {63'd0, (i == 7)});
      if (i == 0) begin
        chk({tag, "_keep"}, {56'd0, tkeep}, 64'hFF);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
      end
      next_cyc();
      clear_reqs();
    end
  endtask

  task automatic idle_after(input string tag);
    @(negedge clk);
    chk({tag, "_done"}, {63'd0, frame_done}, 64'd1);
    chk({tag, "_busy_done"}, {63'd0, busy}, 64'd1);
    chk({tag, "_valid_done"}, {63'd0, tvalid}, 64'd0);
    next_cyc();
    @(negedge clk);
    chk({tag, "_done_clr"}, {63'd0, frame_done}, 64'd0);
    chk({tag, "_busy_clr"}, {63'd0, busy}, 64'd0);
    chk({tag, "_valid_idle"}, {63'd0, tvalid}, 64'd0);
    next_cyc();
  endtask

  initial begin
    logic        pat [4];
    logic [63:0] expd;
    int          acc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; local_time = 64'h1000; std_time = '0; ret_ts = '0;
    tready = 1'b1;
    clear_reqs();
    next_cyc();
    next_cyc();
    @(negedge clk);
    chk("rst_valid", {63'd0, tvalid}, 64'd0);
    chk("rst_data", tdata, 64'd0);
    chk("rst_last", {63'd0, tlast}, 64'd0);
    chk("rst_keep", {56'd0, tkeep}, 64'd0);
    chk("rst_user", {63'd0, tuser}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, frame_done}, 64'd0);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();

    // Single timestamp frame.
    send_ts = 1'b1;
    req_cycle("ts1");
    check_beats("ts1", 64'h66, 64'h1005, 8);
    idle_after("ts1");

    // All three at once: ret, std, ts back-to-back.
    local_time = 64'h2000; std_time = 64'hABCD; ret_ts = 64'h1234;
    send_ts = 1'b1; send_std = 1'b1; send_ret = 1'b1;
    req_cycle("pri");
    check_beats("pri_ret", 64'h55, 64'h1234, 8);
    check_beats("pri_std", 64'h88, 64'hABCD, 8);
    check_beats("pri_ts", 64'h66, 64'h2005, 8);
    idle_after("pri");

    // Backpressure on a std frame.
    std_time = 64'h77; send_std = 1'b1;
    req_cycle("bp");
    acc = 0;
    for (int c = 0; c < 60 && acc < 8; c++) begin
      tready = pat[c % 4];
      @(negedge clk);
      if (tvalid) begin
        expd = (acc == 0) ? 64'h88 : ((acc == 1) ? 64'h77 : 64'd0);
        chk($sformatf("bp_data%0d", acc), tdata, expd);
        chk($sformatf("bp_last%0d", acc), {63'd0, tlast}, {63'd0, (acc == 7)});
        if (tready) acc++;
      end else begin
        chk("bp_gap", {63'd0, tvalid}, 64'd1);
      end
      next_cyc();
    end
    chk("bp_beats", 64'(acc), 64'd8);
    tready = 1'b1;
    idle_after("bp");

    // Overwrite: two std requests while a ts frame is stalled.
    local_time = 64'h5000; tready = 1'b0; send_ts = 1'b1;
    req_cycle("ow");
    send_std = 1'b1; std_time = 64'h1;
    next_cyc();
    std_time = 64'h2;
    next_cyc();
    send_std = 1'b0;
    @(negedge clk);
    chk("ow_stall_data", tdata, 64'h66);
    next_cyc();
    tready = 1'b1;
    check_beats("ow_ts", 64'h66, 64'h5005, 8);
    check_beats("ow_std", 64'h88, 64'h2, 8);
    idle_after("ow");

    // Same-type request on the beat0 handshake gives a second ts frame.
    local_time = 64'h3000; send_ts = 1'b1;
    @(negedge clk);
    chk("col_idle", {63'd0, tvalid}, 64'd0);
    next_cyc();
    check_beats("col_a", 64'h66, 64'h3005, 8);
    local_time = 64'h3100;
    check_beats("col_b", 64'h66, 64'h3105, 8);
    idle_after("col");

    // Reset during beat3 drops the frame and the pending std request.
    ret_ts = 64'h99; std_time = 64'h42; send_ret = 1'b1; send_std = 1'b1;
    req_cycle("mrst");
    check_beats("mrst_ret", 64'h55, 64'h99, 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_b3_data", tdata, 64'd0);
    chk("mrst_b3_valid", {63'd0, tvalid}, 64'd1);
    next_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_valid", {63'd0, tvalid}, 64'd0);
    chk("mrst_data", tdata, 64'd0);
    chk("mrst_last", {63'd0, tlast}, 64'd0);
    chk("mrst_keep", {56'd0, tkeep}, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_done", {63'd0, frame_done}, 64'd0);
    next_cyc();
    @(negedge clk);
    chk("mrst_nopend1", {63'd0, tvalid}, 64'd0);
    next_cyc();
    @(negedge clk);
    chk("mrst_nopend2", {63'd0, tvalid}, 64'd0);
    next_cyc();
    local_time = 64'h4000; send_ts = 1'b1;
    req_cycle("post");
    check_beats("post_ts", 64'h66, 64'h4005, 8);
    idle_after("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
